pwm_rx: RTL and testbench

- Receiving end of the audio PWM link: recovers the 9-bit sample value from a single-bit PWM stream by measuring high time per frame.
- Used for on-board loopback: the left[7] PWM output is wired back into a spare input, and the recovered samples are checked against comb_waveform.
- It also serves as a standalone decoder for external PWM sources.
- Sits beside the pwm block on the hwclk domain.

---
 rtl/pwm_rx.sv | 133 +++++++++++++
 tb/tb_pwm_rx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_rx.sv
// PWM receiver: recovers a WIDTH-bit duty value from a single-bit PWM stream by
// counting high clocks per PERIOD-clock frame, aligned to detected rising edges.
module pwm_rx #(
   parameter int WIDTH       = 9,
   parameter int PERIOD      = 512,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             en,
   input  logic             pwm_i,
   output logic [WIDTH-1:0] sample,
   output logic             done,
   output logic             locked,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HUNT    = 2'd1,
      MEASURE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] FRAME_LAST = WIDTH'(PERIOD - 1);
   localparam logic [WIDTH-1:0] FRAME_ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] SAMPLE_MAX = '1;
   localparam logic [WIDTH:0]   HIGH_ONE   = (WIDTH + 1)'(1);
   localparam logic [WIDTH:0]   HIGH_MAX   = {1'b0, SAMPLE_MAX};

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   s_d;
   logic                   rise;
   logic [WIDTH-1:0]       frame_cnt;
   logic [WIDTH:0]         high_cnt;
   logic [WIDTH:0]         high_final;
   logic [WIDTH-1:0]       high_sat;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, which is what makes the chain a chain.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_q <= '0;
         s_d    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
         s_d    <= s;
      end
   end

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_d;

   // The frame-end cycle's own high bit is folded in before saturation, so a
   // fully-high frame (PERIOD counts) clamps to the largest sample value.
   assign high_final = high_cnt + {{WIDTH{1'b0}}, s};
   assign high_sat   = (high_final > HIGH_MAX) ? SAMPLE_MAX : high_final[WIDTH-1:0];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         frame_cnt <= '0;
         high_cnt  <= '0;
         sample    <= '0;
         done      <= 1'b0;
         locked    <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (!en) begin
            state     <= IDLE;
            frame_cnt <= '0;
            high_cnt  <= '0;
            locked    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  frame_cnt <= '0;
                  high_cnt  <= '0;
                  locked    <= 1'b0;
                  state     <= HUNT;
               end

               // frame_cnt doubles as a no-edge timeout for constant inputs.
               HUNT: begin
                  locked   <= 1'b0;
                  high_cnt <= '0;
                  if (rise) begin
                     state     <= MEASURE;
                     locked    <= 1'b1;
                     frame_cnt <= FRAME_ONE;
                     high_cnt  <= HIGH_ONE;
                  end else if (frame_cnt == FRAME_LAST) begin
                     done      <= 1'b1;
                     sample    <= s ? SAMPLE_MAX : '0;
                     frame_cnt <= '0;
                  end else begin
                     frame_cnt <= frame_cnt + FRAME_ONE;
                  end
               end

               MEASURE: begin
                  locked <= 1'b1;
                  if (rise && (frame_cnt != '0)) begin
                     // Misaligned edge: drop this frame and restart on it.
                     err       <= 1'b1;
                     frame_cnt <= FRAME_ONE;
                     high_cnt  <= HIGH_ONE;
                  end else if (frame_cnt == FRAME_LAST) begin
                     done      <= 1'b1;
                     sample    <= high_sat;
                     frame_cnt <= '0;
                     high_cnt  <= '0;
                  end else begin
                     frame_cnt <= frame_cnt + FRAME_ONE;
                     high_cnt  <= high_final;
                  end
               end

               default: begin
                  state     <= IDLE;
                  frame_cnt <= '0;
                  high_cnt  <= '0;
                  locked    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_rx.sv
// Directed bench for pwm_rx: drives a phase-controlled PWM source and checks
// lock timing, recovered samples, strobes and reset/enable behaviour.
module tb_pwm_rx;

   localparam int WIDTH  = 9;
   localparam int PERIOD = 512;

   logic             clk = 1'b0;
   logic             n_rst;
   logic             en;
   logic             pwm_i;
   logic [WIDTH-1:0] sample;
   logic             done;
   logic             locked;
   logic             err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference source: gen_mode 0 drives gen_level, 1 drives a PWM of gen_duty.
   int   gen_mode;
   logic gen_level;
   int   gen_duty;
   int   gen_phase;

   int   done_cnt;
   int   err_cnt;
   int   both_cnt;
   int   last_done_cyc;
   int   prev_done_cyc;
   int   mark;
   int   sweep_vals [5] = '{0, 1, 255, 510, 511};

   always #5 clk = ~clk;

   pwm_rx #(
      .WIDTH      (WIDTH),
      .PERIOD     (PERIOD),
      .SYNC_STAGES(2)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (en),
      .pwm_i (pwm_i),
      .sample(sample),
      .done  (done),
      .locked(locked),
      .err   (err)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // One clock: sample outputs 1 time unit after the edge, then drive the source.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
         done_cnt++;
         prev_done_cyc = last_done_cyc;
         last_done_cyc = cyc;
      end
      if (err) err_cnt++;
      if (done && err) both_cnt++;
      if (gen_mode == 1) begin
         pwm_i     = (gen_phase < gen_duty);
         gen_phase = (gen_phase + 1) % PERIOD;
      end else begin
         pwm_i = gen_level;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic to_phase(input int p);
      for (int guard = 0; (gen_phase != p) && (guard < 2 * PERIOD); guard++) step();
   endtask

   task automatic clear_mon();
      done_cnt      = 0;
      err_cnt       = 0;
      last_done_cyc = -1;
      prev_done_cyc = -1;
   endtask

   initial begin
      n_rst     = 1'b0;
      en        = 1'b0;
      pwm_i     = 1'b0;
      gen_mode  = 0;
      gen_level = 1'b0;
      gen_duty  = 0;
      gen_phase = 0;
      both_cnt  = 0;
      clear_mon();

      // Reset state
      run(3);
      check("rst_sample", sample, 0);
      check("rst_done", done, 0);
      check("rst_locked", locked, 0);
      check("rst_err", err, 0);
      n_rst = 1'b1;
      run(2);

      // Constant 0 in HUNT: timeout done every PERIOD clocks, unlocked
      clear_mon();
      en = 1'b1;
      run(512);
      check("c0_no_early_done", done_cnt, 0);
      run(1);
      check("c0_done1", done, 1);
      check("c0_sample1", sample, 0);
      check("c0_unlocked", locked, 0);
      run(512);
      check("c0_done2", done, 1);
      check("c0_spacing", last_done_cyc - prev_done_cyc, 512);
      check("c0_unlocked2", locked, 0);

      // 25% duty: lock three clocks after the first edge, done every frame
      gen_mode  = 1;
      gen_duty  = 128;
      gen_phase = 0;
      clear_mon();
      run(1);
      run(2);
      check("lk_not_yet", locked, 0);
      run(1);
      check("lk_locked", locked, 1);
      clear_mon();
      run(511);
      check("d25_done1", done, 1);
      check("d25_sample1", sample, 128);
      run(512);
      check("d25_done2", done, 1);
      check("d25_sample2", sample, 128);
      check("d25_spacing", last_done_cyc - prev_done_cyc, 512);
      check("d25_no_err", err_cnt, 0);

      // Glitch: source jumps phase so a new edge lands at frame cycle 300
      to_phase(300);
      gen_phase = 0;
      clear_mon();
      run(1);
      run(2);
      check("gl_err_not_yet", err, 0);
      run(1);
      check("gl_err", err, 1);
      check("gl_err_no_done", done, 0);
      check("gl_still_locked", locked, 1);
      run(510);
      check("gl_no_old_done", done_cnt, 0);
      check("gl_err_once", err_cnt, 1);
      run(1);
      check("gl_done", done, 1);
      check("gl_sample", sample, 128);

      // Duty sweep, each change applied at a frame boundary
      clear_mon();
      for (int k = 0; k < 5; k++) begin
         to_phase(0);
         gen_duty = sweep_vals[k];
         run(515);
         check($sformatf("sw_done_%0d", sweep_vals[k]), done, 1);
         check($sformatf("sw_sample_%0d", sweep_vals[k]), sample, sweep_vals[k]);
      end
      check("sw_no_err", err_cnt, 0);

      // Constant high after an edge saturates to 511 while locked
      to_phase(0);
      gen_duty = PERIOD;
      run(515);
      check("c1_done1", done, 1);
      check("c1_sample1", sample, 511);
      run(512);
      check("c1_done2", done, 1);
      check("c1_sample2", sample, 511);
      check("c1_locked", locked, 1);

      // Enable drop mid-frame, then relock on the next edge
      to_phase(0);
      gen_duty = 128;
      run(515);
      check("en_pre_sample", sample, 128);
      to_phase(200);
      run(1);
      en = 1'b0;
      clear_mon();
      run(1);
      check("en_unlocked", locked, 0);
      check("en_no_done", done, 0);
      run(600);
      check("en_no_done_cnt", done_cnt, 0);
      check("en_no_err_cnt", err_cnt, 0);
      check("en_sample_held", sample, 128);
      to_phase(100);
      en = 1'b1;
      to_phase(0);
      run(1);
      run(2);
      check("re_not_yet", locked, 0);
      run(1);
      check("re_locked", locked, 1);
      run(511);
      check("re_done", done, 1);
      check("re_sample", sample, 128);

      // Asynchronous reset mid-frame clears outputs without waiting for a clock
      to_phase(400);
      run(1);
      #2;
      n_rst = 1'b0;
      #1;
      check("ar_sample", sample, 0);
      check("ar_locked", locked, 0);
      check("ar_done", done, 0);
      check("ar_err", err, 0);
      clear_mon();
      run(3);
      n_rst = 1'b1;
      to_phase(0);
      run(1);
      run(2);
      check("ar_not_yet", locked, 0);
      run(1);
      check("ar_relocked", locked, 1);
      run(511);
      check("ar_done1", done, 1);
      check("ar_sample1", sample, 128);
      run(512);
      check("ar_done2", done, 1);
      check("ar_sample2", sample, 128);
      check("ar_done_cnt", done_cnt, 2);

      // Constant high from reset with no edge: timeout reports 511, unlocked
      n_rst     = 1'b0;
      en        = 1'b0;
      gen_mode  = 0;
      gen_level = 1'b1;
      run(2);
      n_rst = 1'b1;
      run(5);
      clear_mon();
      en = 1'b1;
      run(513);
      check("h0_done", done, 1);
      check("h0_sample", sample, 511);
      check("h0_unlocked", locked, 0);
      check("h0_no_err", err_cnt, 0);

      check("never_done_and_err", both_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
